burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
- Memory-side responder for the 64-bit, 4-beat burst protocol driven by cacheline_adaptor toward physical memory.
- Accepts line-granular read and write requests and returns or consumes four 64-bit beats after a programmable access latency.
- Serves as the synthesizable physical-memory model behind mp3 for simulation and FPGA bring-up.
- Includes a backdoor preload port so benches can initialise contents.

Parameters:
- LINE_BITS, 8, log2 of number of 256-bit lines stored (default 256 lines = 8 KiB).
- LATENCY, 6, cycles from request acceptance to first resp_o beat; legal range 1..255.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- read_i  in  1  line read request, held high by initiator until burst completes
- write_i  in  1  line write request, held high by initiator until burst completes
- address_i  in  32  byte address; bits [4:0] ignored
- burst_i  in  64  write beat from initiator, sampled in every cycle resp_o=1 during a write
- burst_o  out  64  read beat, valid in every cycle resp_o=1 during a read
- resp_o  out  1  beat strobe; high for exactly 4 consecutive cycles per transaction
- err_o  out  1  sticky protocol-error flag
- init_we_i  in  1  backdoor line write, only honoured in IDLE
- init_idx_i  in  LINE_BITS  backdoor line index
- init_line_i  in  256  backdoor line data

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, resp_o=0, burst_o=0, err_o=0, counters=0. The storage array is not cleared. A reset mid-transaction aborts it and leaves already-written beats committed.
- Index = address_i[LINE_BITS+4:5]. Upper address bits are ignored, so addresses wrap modulo depth.
- Beat k (0..3) maps to line bits [64k+63:64k], i.e. beat 0 is the lowest byte address.
- States:
  - IDLE: on read_i^write_i, latch index and direction, load latency counter with LATENCY-1, go to WAIT. If read_i&write_i are both high, set err_o, stay IDLE and issue no response. When init_we_i=1 with no request, write init_line_i to init_idx_i. A request in the same cycle wins and the init write is dropped.
  - WAIT: decrement the counter. At 0, go to READ_BURST or WRITE_BURST with beat=0. If the request drops during WAIT, abort to IDLE silently.
  - READ_BURST: resp_o=1, burst_o=mem[idx][beat], all registered. beat increments each cycle; after beat 3 go to DONE.
  - WRITE_BURST: resp_o=1. At each edge with resp_o=1, write burst_i into mem[idx][beat]. beat increments each cycle; after beat 3 go to DONE.
  - DONE: resp_o=0. Go to IDLE once read_i=0 and write_i=0.
- Request dropping or direction changing during a burst: set err_o, abort to DONE, resp_o=0 next cycle.
- Latency: with a request first high at edge t, resp_o is high on cycles t+LATENCY .. t+LATENCY+3.
- Back-to-back transactions need at least one cycle with both requests low.
- address_i is sampled only at acceptance; later changes are ignored.
- burst_o holds its last value whenever resp_o=0.

Decomposition:
- Shared package (rv32i_types or a new pmem_types):
  - burst_beats_t constant = 4
  - beat width = 64, line width = 256
  - pmem_state_t enum {IDLE, WAIT, READ_BURST, WRITE_BURST, DONE}
- One natural sub-module: burst_mem_array, a 2^LINE_BITS x 256 storage with a 64-bit beat write enable, one 64-bit beat read port and a 256-bit init write port. The FSM and counters stay in the top.

Test Plan:
- Reset then read: preload idx 3 with beats {A0,A1,A2,A3} = 64'h1111..,64'h2222..,64'h3333..,64'h4444.., then read_i with address 0x0000_0060 at t → resp_o high exactly at t+6..t+9 with burst_o = A0,A1,A2,A3 in order; resp_o=0 at t+10.
- Write then read: write 0x0000_0080 with burst_i beats 0xDEAD0000_00000000+k → a subsequent read of 0x0000_0080 returns identical beats; neighbouring idx 5 is unchanged.
- Wrap and alignment: read 0x0000_2064 with LINE_BITS=8 → returns line idx 3, since bits [4:0] and upper bits are ignored.
- Protocol errors:
  - read_i and write_i together → err_o=1, no resp_o.
  - read dropped at beat 1 → err_o=1, resp_o=0 next cycle, FSM in DONE.
  - reset_n=0 → err_o cleared.
- Reset mid-write after 2 beats → resp_o=0 the next cycle; beats 0 and 1 committed, beats 2 and 3 retain old data.
- LATENCY=1 and LATENCY=255 builds → first resp_o at t+1 and t+255 respectively; an abort during WAIT produces no resp_o and no err_o.

Source files
------------

// File: rtl/burst_mem_responder_pkg.sv
// burst_mem_responder_pkg: beat/line geometry and FSM encodings for the burst memory responder
package burst_mem_responder_pkg;
    localparam int BURST_BEATS = 4;
    localparam int BEAT_W = 64;
    localparam int LINE_W = BURST_BEATS * BEAT_W;
    typedef logic [2:0] pmem_state_t;
    localparam pmem_state_t ST_IDLE  = 3'd0;
    localparam pmem_state_t ST_WAIT  = 3'd1;
    localparam pmem_state_t ST_READ  = 3'd2;
    localparam pmem_state_t ST_WRITE = 3'd3;
    localparam pmem_state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/burst_mem_responder_if.sv
// burst_mem_responder_if: line request and 64-bit beat bus between initiator and memory responder
interface burst_mem_responder_if;
    import burst_mem_responder_pkg::*;
    logic              read;
    logic              write;
    logic [31:0]       address;
    logic [BEAT_W-1:0] wbeat;
    logic [BEAT_W-1:0] rbeat;
    logic              resp;
    logic              err;
    modport master (output read, write, address, wbeat, input rbeat, resp, err);
    modport slave  (input read, write, address, wbeat, output rbeat, resp, err);
endinterface

// File: rtl/burst_mem_responder_array.sv
// burst_mem_responder_array: line storage with one beat read port, one beat write port and a full-line init port
module burst_mem_responder_array
    import burst_mem_responder_pkg::*;
#(
    parameter int LINE_BITS = 8
) (
    input  logic                 clk,
    input  logic [LINE_BITS-1:0] idx,
    input  logic                 beat_we,
    input  logic [1:0]           wr_sel,
    input  logic [BEAT_W-1:0]    wr_beat,
    input  logic [1:0]           rd_sel,
    output logic [BEAT_W-1:0]    rd_beat,
    input  logic                 init_we,
    input  logic [LINE_BITS-1:0] init_idx,
    input  logic [LINE_W-1:0]    init_line
);
    logic [LINE_W-1:0] mem [2**LINE_BITS];
    always_ff @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_line;
        if (beat_we) mem[idx][{wr_sel, 6'd0} +: BEAT_W] <= wr_beat;
    end
    assign rd_beat = mem[idx][{rd_sel, 6'd0} +: BEAT_W];
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 4-beat line read/write responder with programmable access latency
module burst_mem_responder
    import burst_mem_responder_pkg::*;
#(
    parameter int LINE_BITS = 8,
    parameter int LATENCY   = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    burst_mem_responder_if.slave bus,
    input  logic                 init_we,
    input  logic [LINE_BITS-1:0] init_idx,
    input  logic [LINE_W-1:0]    init_line
);
    pmem_state_t          state;
    logic [LINE_BITS-1:0] idx;
    logic                 is_read;
    logic [7:0]           cnt;
    logic [1:0]           beat;
    logic [BEAT_W-1:0]    rd_beat;
    logic                 held;
    logic                 unused_addr;
    assign held        = is_read ? (bus.read & ~bus.write) : (bus.write & ~bus.read);
    assign unused_addr = ^bus.address;
    // the read port looks one beat ahead so burst_o can be registered
    burst_mem_responder_array #(.LINE_BITS(LINE_BITS)) u_array (
        .clk      (clk),
        .idx      (idx),
        .beat_we  (reset_n && state == ST_WRITE && held),
        .wr_sel   (beat),
        .wr_beat  (bus.wbeat),
        .rd_sel   (state == ST_WAIT ? 2'd0 : beat + 2'd1),
        .rd_beat  (rd_beat),
        .init_we  (init_we && state == ST_IDLE && !bus.read && !bus.write),
        .init_idx (init_idx),
        .init_line(init_line)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bus.resp  <= 1'b0;
            bus.rbeat <= '0;
            bus.err   <= 1'b0;
            cnt       <= '0;
            beat      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.read && bus.write) begin
                        bus.err <= 1'b1;
                    end else if (bus.read || bus.write) begin
                        idx     <= bus.address[LINE_BITS+4:5];
                        is_read <= bus.read;
                        cnt     <= 8'(LATENCY - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!held) begin
                        state <= ST_IDLE;
                    end else if (cnt == 8'd0) begin
                        state    <= is_read ? ST_READ : ST_WRITE;
                        bus.resp <= 1'b1;
                        beat     <= 2'd0;
                        if (is_read) bus.rbeat <= rd_beat;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (!held) begin
                        bus.err  <= 1'b1;
                        bus.resp <= 1'b0;
                        state    <= ST_DONE;
                    end else if (beat == 2'd3) begin
                        bus.resp <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        beat <= beat + 2'd1;
                        if (is_read) bus.rbeat <= rd_beat;
                    end
                end
                ST_DONE: if (!bus.read && !bus.write) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: directed checks of latency, beat order, write commit, wrap and protocol errors
module tb_burst_mem_responder;
    import burst_mem_responder_pkg::*;
    localparam int LAT = 6;
    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_N = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                                       64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    localparam logic [255:0] LINE_C = {64'hC0C0_0000_0000_0003, 64'hC0C0_0000_0000_0002,
                                       64'hC0C0_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    localparam logic [255:0] LINE_W = {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002,
                                       64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
    localparam logic [255:0] LINE_B = {64'hBEEF_0000_0000_0003, 64'hBEEF_0000_0000_0002,
                                       64'hBEEF_0000_0000_0001, 64'hBEEF_0000_0000_0000};
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init_we = 1'b0;
    logic [7:0]   init_idx = '0;
    logic [255:0] init_line = '0;
    logic         saw;
    logic         saw1;
    int           n_cmp = 0;
    int           n_bad = 0;
    burst_mem_responder_if bus();
    burst_mem_responder_if b1();
    burst_mem_responder_if b255();
    always #5 clk = ~clk;
    burst_mem_responder #(.LINE_BITS(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .init_we(init_we), .init_idx(init_idx), .init_line(init_line));
    burst_mem_responder #(.LINE_BITS(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .bus(b1),
        .init_we(1'b0), .init_idx(8'd0), .init_line(256'd0));
    burst_mem_responder #(.LINE_BITS(8), .LATENCY(255)) dut_l255 (
        .clk(clk), .reset_n(reset_n), .bus(b255),
        .init_we(1'b0), .init_idx(8'd0), .init_line(256'd0));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [255:0] line);
        init_we = 1'b1;
        init_idx = idx;
        init_line = line;
        tick();
        init_we = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [255:0] exp);
        bus.read = 1'b1;
        bus.address = a;
        for (int k = 0; k <= LAT + 4; k++) begin
            tick();
            check($sformatf("%s_resp%0d", tag, k), bus.resp, k >= LAT && k <= LAT + 3);
            if (k >= LAT && k <= LAT + 3)
                check($sformatf("%s_beat%0d", tag, k - LAT), bus.rbeat, exp[64*(k-LAT) +: 64]);
        end
        bus.read = 1'b0;
        tick();
        tick();
    endtask

    // n < 4 asserts reset while beat n is on the bus, so only beats 0..n-1 commit
    task automatic do_write(input string tag, input logic [31:0] a, input logic [255:0] line, input int n);
        bus.write = 1'b1;
        bus.address = a;
        for (int k = 0; k <= LAT + 4; k++) begin
            tick();
            check($sformatf("%s_resp%0d", tag, k), bus.resp, k >= LAT && k <= LAT + 3);
            if (k >= LAT && k <= LAT + 3) bus.wbeat = line[64*(k-LAT) +: 64];
            if (n < 4 && k == LAT + n) begin
                reset_n = 1'b0;
                bus.write = 1'b0;
                tick();
                check({tag, "_rst_resp"}, bus.resp, 0);
                reset_n = 1'b1;
                break;
            end
        end
        bus.write = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        {bus.read, bus.write, bus.address, bus.wbeat} = '0;
        {b1.read, b1.write, b1.address, b1.wbeat} = '0;
        {b255.read, b255.write, b255.address, b255.wbeat} = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_resp", bus.resp, 0);
        check("rst_err", bus.err, 0);
        check("rst_beat", bus.rbeat, 0);
        preload(8'd3, LINE_A);
        preload(8'd5, LINE_N);
        preload(8'd6, LINE_C);
        do_read("rd3", 32'h0000_0060, LINE_A);
        do_write("wr4", 32'h0000_0080, LINE_W, 4);
        do_read("rd4", 32'h0000_0080, LINE_W);
        do_read("rd5", 32'h0000_00A0, LINE_N);
        do_read("wrap", 32'h0000_2064, LINE_A);
        bus.read = 1'b1;
        bus.write = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            tick();
            saw |= bus.resp;
        end
        check("both_resp", saw, 0);
        check("both_err", bus.err, 1);
        bus.read = 1'b0;
        bus.write = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        check("rst_err_clr", bus.err, 0);
        reset_n = 1'b1;
        tick();
        bus.read = 1'b1;
        bus.address = 32'h0000_0060;
        for (int k = 0; k <= LAT + 1; k++) tick();
        check("drop_beat1", bus.rbeat, LINE_A[127:64]);
        bus.read = 1'b0;
        tick();
        check("drop_resp", bus.resp, 0);
        check("drop_err", bus.err, 1);
        check("drop_hold", bus.rbeat, LINE_A[127:64]);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_write("rstw", 32'h0000_00C0, LINE_B, 2);
        do_read("rd6", 32'h0000_00C0, {LINE_C[255:128], LINE_B[127:0]});
        bus.read = 1'b1;
        bus.address = 32'h0000_0060;
        repeat (3) tick();
        bus.read = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            tick();
            saw |= bus.resp;
        end
        check("wabort_resp", saw, 0);
        check("wabort_err", bus.err, 0);
        b1.read = 1'b1;
        b255.read = 1'b1;
        for (int k = 0; k <= 259; k++) begin
            tick();
            check($sformatf("l1_resp%0d", k), b1.resp, k >= 1 && k <= 4);
            check($sformatf("l255_resp%0d", k), b255.resp, k >= 255 && k <= 258);
        end
        b1.read = 1'b0;
        b255.read = 1'b0;
        repeat (2) tick();
        b1.read = 1'b1;
        b255.read = 1'b1;
        tick();
        b1.read = 1'b0;
        saw = 1'b0;
        saw1 = 1'b0;
        repeat (100) begin
            tick();
            saw1 |= b1.resp;
            saw |= b255.resp;
        end
        b255.read = 1'b0;
        repeat (300) begin
            tick();
            saw |= b255.resp;
        end
        check("l1_abort_resp", saw1, 0);
        check("l1_abort_err", b1.err, 0);
        check("l255_abort_resp", saw, 0);
        check("l255_abort_err", b255.err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
